// File: rtl/qkv_proj.sv
// Q/K/V linear projection: three run-time-loadable OUT_DIM x EMBED_DIM weight matrices, fixed-point MAC, round + saturate.
// Latency: done pulses the cycle after edge OUT_DIM*(EMBED_DIM+1)+1 counted from the accepting start edge.
// No backpressure: start and weight writes are only honoured in IDLE; while busy they are dropped, never queued.
module qkv_proj #(
    parameter int DATA_WIDTH = 16,
    parameter int EMBED_DIM  = 8,
    parameter int OUT_DIM    = 8,
    parameter int FRAC_BITS  = 14,
    localparam int ROW_W     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1,
    localparam int COL_W     = $clog2(EMBED_DIM)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            w_wr_en,
    input  logic [1:0]                      w_sel,
    input  logic [ROW_W-1:0]                w_row,
    input  logic [COL_W-1:0]                w_col,
    input  logic [DATA_WIDTH-1:0]           w_data,
    input  logic                            start,
    input  logic [DATA_WIDTH*EMBED_DIM-1:0] input_vec_flat,
    output logic                            busy,
    output logic                            done,
    output logic                            sat_flag,
    output logic [DATA_WIDTH*OUT_DIM-1:0]   Q_flat,
    output logic [DATA_WIDTH*OUT_DIM-1:0]   K_flat,
    output logic [DATA_WIDTH*OUT_DIM-1:0]   V_flat
);

    localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(EMBED_DIM);

    // Rounding constant and clamp limits, one bit wider than the accumulator so the add cannot wrap.
    localparam logic signed [ACC_WIDTH:0] RND     = (ACC_WIDTH+1)'(64'sd1 <<< (FRAC_BITS-1));
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t                        state;
    logic [ROW_W-1:0]              row_idx;
    logic [COL_W-1:0]              col_idx;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_k, acc_v;
    logic signed [DATA_WIDTH-1:0]  x_cap [EMBED_DIM];
    logic signed [DATA_WIDTH-1:0]  q_r [OUT_DIM];
    logic signed [DATA_WIDTH-1:0]  k_r [OUT_DIM];
    logic signed [DATA_WIDTH-1:0]  v_r [OUT_DIM];
    logic signed [DATA_WIDTH-1:0]  wq [OUT_DIM][EMBED_DIM];
    logic signed [DATA_WIDTH-1:0]  wk [OUT_DIM][EMBED_DIM];
    logic signed [DATA_WIDTH-1:0]  wv [OUT_DIM][EMBED_DIM];
    logic signed [2*DATA_WIDTH-1:0] prod_q, prod_k, prod_v;
    logic [DATA_WIDTH:0]           rs_q, rs_k, rs_v;
    logic                          w_ok;

    // Returns {clamped, value}: add half an LSB, arithmetic shift (round half toward +inf), then clamp.
    function automatic logic [DATA_WIDTH:0] rnd_sat(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH:0] t;
        t = ($signed({acc[ACC_WIDTH-1], acc}) + RND) >>> FRAC_BITS;
        if (t > SAT_MAX)
            rnd_sat = {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        else if (t < SAT_MIN)
            rnd_sat = {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        else
            rnd_sat = {1'b0, t[DATA_WIDTH-1:0]};
    endfunction

    assign busy   = (state != IDLE);
    assign w_ok   = w_wr_en && (state == IDLE) && (32'(w_row) < OUT_DIM) && (32'(w_col) < EMBED_DIM);
    assign prod_q = x_cap[col_idx] * wq[row_idx][col_idx];
    assign prod_k = x_cap[col_idx] * wk[row_idx][col_idx];
    assign prod_v = x_cap[col_idx] * wv[row_idx][col_idx];
    assign rs_q   = rnd_sat(acc_q);
    assign rs_k   = rnd_sat(acc_k);
    assign rs_v   = rnd_sat(acc_v);

    for (genvar g = 0; g < OUT_DIM; g++) begin : g_out
        assign Q_flat[g*DATA_WIDTH +: DATA_WIDTH] = q_r[g];
        assign K_flat[g*DATA_WIDTH +: DATA_WIDTH] = k_r[g];
        assign V_flat[g*DATA_WIDTH +: DATA_WIDTH] = v_r[g];
    end

    // Weight store: one element per cycle, only while idle so a running projection sees stable weights.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < OUT_DIM; r++) begin
                for (int c = 0; c < EMBED_DIM; c++) begin
                    wq[r][c] <= '0;
                    wk[r][c] <= '0;
                    wv[r][c] <= '0;
                end
            end
        end else if (w_ok) begin
            case (w_sel)
                2'd0:    wq[w_row][w_col] <= w_data;
                2'd1:    wk[w_row][w_col] <= w_data;
                2'd2:    wv[w_row][w_col] <= w_data;
                default: ;
            endcase
        end
    end

    // Projection FSM: per row, EMBED_DIM MAC cycles then one WRITE cycle; DONE raises the completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row_idx  <= '0;
            col_idx  <= '0;
            acc_q    <= '0;
            acc_k    <= '0;
            acc_v    <= '0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
            for (int e = 0; e < EMBED_DIM; e++) x_cap[e] <= '0;
            for (int o = 0; o < OUT_DIM; o++) begin
                q_r[o] <= '0;
                k_r[o] <= '0;
                v_r[o] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int e = 0; e < EMBED_DIM; e++)
                            x_cap[e] <= input_vec_flat[e*DATA_WIDTH +: DATA_WIDTH];
                        row_idx  <= '0;
                        col_idx  <= '0;
                        acc_q    <= '0;
                        acc_k    <= '0;
                        acc_v    <= '0;
                        sat_flag <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_q + ACC_WIDTH'(prod_q);
                    acc_k <= acc_k + ACC_WIDTH'(prod_k);
                    acc_v <= acc_v + ACC_WIDTH'(prod_v);
                    if (col_idx == COL_W'(EMBED_DIM-1))
                        state <= WRITE;
                    else
                        col_idx <= col_idx + COL_W'(1);
                end
                WRITE: begin
                    q_r[row_idx] <= rs_q[DATA_WIDTH-1:0];
                    k_r[row_idx] <= rs_k[DATA_WIDTH-1:0];
                    v_r[row_idx] <= rs_v[DATA_WIDTH-1:0];
                    sat_flag     <= sat_flag | rs_q[DATA_WIDTH] | rs_k[DATA_WIDTH] | rs_v[DATA_WIDTH];
                    if (row_idx == ROW_W'(OUT_DIM-1)) begin
                        state <= DONE;
                    end else begin
                        row_idx <= row_idx + ROW_W'(1);
                        col_idx <= '0;
                        acc_q   <= '0;
                        acc_k   <= '0;
                        acc_v   <= '0;
                        state   <= MAC;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qkv_proj.sv
// Scoreboard bench for qkv_proj at EMBED_DIM=OUT_DIM=4, DATA_WIDTH=16, FRAC_BITS=14.
// Stimulus pushes hand-computed results and the expected done cycle; a monitor pops on every done pulse.
// Any done pulse with nothing pending is reported as a failure.
module tb_qkv_proj;
    localparam int DW = 16;
    localparam int E  = 4;
    localparam int O  = 4;
    localparam int F  = 14;
    localparam int L  = O*(E+1)+1;

    logic          clk, rst_n;
    logic          w_wr_en;
    logic [1:0]    w_sel;
    logic [1:0]    w_row;
    logic [1:0]    w_col;
    logic [DW-1:0] w_data;
    logic          start;
    logic [DW*E-1:0] input_vec_flat;
    logic          busy, done, sat_flag;
    logic [DW*O-1:0] Q_flat, K_flat, V_flat;

    qkv_proj #(.DATA_WIDTH(DW), .EMBED_DIM(E), .OUT_DIM(O), .FRAC_BITS(F)) dut (
        .clk(clk), .rst_n(rst_n), .w_wr_en(w_wr_en), .w_sel(w_sel), .w_row(w_row),
        .w_col(w_col), .w_data(w_data), .start(start), .input_vec_flat(input_vec_flat),
        .busy(busy), .done(done), .sat_flag(sat_flag),
        .Q_flat(Q_flat), .K_flat(K_flat), .V_flat(V_flat)
    );

    typedef struct {
        string       name;
        logic [63:0] q, k, v;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with no run pending", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_done_cycle"}, 64'(cyc), 64'(mon_e.cyc));
                check({mon_e.name, "_Q"}, Q_flat, mon_e.q);
                check({mon_e.name, "_K"}, K_flat, mon_e.k);
                check({mon_e.name, "_V"}, V_flat, mon_e.v);
                check({mon_e.name, "_sat"}, 64'(sat_flag), 64'(mon_e.sat));
                check({mon_e.name, "_busy_fall"}, 64'(busy), 64'd0);
            end
        end
    end

    task automatic wr(input int s, input int r, input int c, input int d);
        w_sel   = 2'(s);
        w_row   = 2'(r);
        w_col   = 2'(c);
        w_data  = 16'(d);
        w_wr_en = 1'b1;
        @(negedge clk);
        w_wr_en = 1'b0;
    endtask

    task automatic fill(input int s, input int val);
        for (int r = 0; r < O; r++)
            for (int c = 0; c < E; c++)
                wr(s, r, c, val);
    endtask

    task automatic diag(input int s, input int val);
        for (int r = 0; r < O; r++)
            for (int c = 0; c < E; c++)
                wr(s, r, c, (r == c) ? val : 0);
    endtask

    task automatic run(input string nm, input logic [63:0] x, input logic [63:0] q,
                       input logic [63:0] k, input logic [63:0] v, input logic s);
        exp_t e;
        e.name = nm; e.q = q; e.k = k; e.v = v; e.sat = s; e.cyc = cyc + 1 + L;
        input_vec_flat = x;
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check({nm, "_busy_rise"}, 64'(busy), 64'd1);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d runs still pending, expected 0", nm, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; w_wr_en = 1'b0; w_sel = '0; w_row = '0; w_col = '0;
        w_data = '0; start = 1'b0; input_vec_flat = '0;

        // Reset held with random inputs: everything stays at zero.
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            w_wr_en = 1'($urandom); w_sel = 2'($urandom); w_row = 2'($urandom);
            w_col = 2'($urandom); w_data = 16'($urandom); start = 1'($urandom);
            input_vec_flat = {$urandom, $urandom};
            #1;
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_sat", 64'(sat_flag), 64'd0);
            check("rst_Q", Q_flat, 64'd0);
            check("rst_K", K_flat, 64'd0);
            check("rst_V", V_flat, 64'd0);
        end
        @(negedge clk);
        w_wr_en = 1'b0; start = 1'b0;
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_Q", Q_flat, 64'd0);
        check("idle_sat", 64'(sat_flag), 64'd0);

        // Identity projection: Q=K=V=x.
        diag(0, 16384); diag(1, 16384); diag(2, 16384);
        run("ident", pack4(100, -200, 300, -32768), pack4(100, -200, 300, -32768),
            pack4(100, -200, 300, -32768), pack4(100, -200, 300, -32768), 1'b0);
        drain("ident");

        // Distinct matrices, round half toward +inf: 1.5 -> 2, -1.5 -> -1.
        fill(0, 0); fill(1, 0); fill(2, 0);
        wr(0, 0, 0, 8192); wr(1, 0, 0, -8192); wr(2, 0, 0, 16384);
        run("distinct", pack4(3, 7, -5, 9), pack4(2, 0, 0, 0), pack4(-1, 0, 0, 0),
            pack4(3, 0, 0, 0), 1'b0);
        drain("distinct");

        // Saturation both ways, and sat_flag cleared by the next start.
        fill(0, 16384); fill(1, 16384); fill(2, 16384);
        run("sat_pos", pack4(8192, 8192, 8192, 8192), 64'h7fff7fff7fff7fff,
            64'h7fff7fff7fff7fff, 64'h7fff7fff7fff7fff, 1'b1);
        drain("sat_pos");
        run("sat_zero", 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        drain("sat_zero");
        run("sat_neg", pack4(-16384, -16384, -16384, -16384), 64'h8000800080008000,
            64'h8000800080008000, 64'h8000800080008000, 1'b1);
        drain("sat_neg");

        // Weight write and start during a run are both dropped.
        run("busy_a", pack4(100, 200, 300, 400), pack4(1000, 1000, 1000, 1000),
            pack4(1000, 1000, 1000, 1000), pack4(1000, 1000, 1000, 1000), 1'b0);
        repeat (5) @(negedge clk);
        start = 1'b1;
        wr(0, 0, 0, -16384);
        start = 1'b0;
        drain("busy_a");
        repeat (L + 5) @(negedge clk);
        run("busy_b", pack4(100, 200, 300, 400), pack4(1000, 1000, 1000, 1000),
            pack4(1000, 1000, 1000, 1000), pack4(1000, 1000, 1000, 1000), 1'b0);
        drain("busy_b");

        // Reset at edge 10 of a run: immediate zero outputs, no done pulse.
        input_vec_flat = pack4(100, 200, 300, 400);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_Q", Q_flat, 64'd0);
        check("midrst_K", K_flat, 64'd0);
        check("midrst_V", V_flat, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        // Weights were lost: a run without reloading gives zeros.
        run("lost_w", pack4(100, 200, 300, 400), 64'd0, 64'd0, 64'd0, 1'b0);
        drain("lost_w");

        // Reload identity and confirm a correct result at edge L.
        diag(0, 16384); diag(1, 16384); diag(2, 16384);
        run("reload", pack4(1234, -5678, 32767, -1), pack4(1234, -5678, 32767, -1),
            pack4(1234, -5678, 32767, -1), pack4(1234, -5678, 32767, -1), 1'b0);
        drain("reload");

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
